// File: rtl/intersection_ctrl.sv
// Four-way intersection controller: NS/EW signal phases, pedestrian walk, emergency preemption.
// Latency: lights, walk and ped_ack are registered from the next state, so they change on the same edge as state_o.
// Backpressure: none; sensor and button inputs are latched into pending flags until serviced.
module intersection_ctrl #(
  parameter int GREEN_NS = 15,
  parameter int GREEN_EW = 10,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_NS_G  = 3'd0,
    S_NS_Y  = 3'd1,
    S_AR1   = 3'd2,
    S_EW_G  = 3'd3,
    S_EW_Y  = 3'd4,
    S_AR2   = 3'd5,
    S_WALK  = 3'd6,
    S_EMERG = 3'd7
  } state_t;

  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  state_t     state;
  state_t     nxt;
  logic [7:0] timer;
  logic       car_pend;
  logic       ped_pend;
  logic       expired;
  logic       entering;
  logic       enter_ew_g;
  logic       enter_walk;

  // Dwell of each state minus one; EMERG has no dwell of its own, it simply holds.
  function automatic logic [7:0] dur_m1(input state_t s);
    case (s)
      S_NS_G:  dur_m1 = 8'(GREEN_NS - 1);
      S_NS_Y:  dur_m1 = 8'(YELLOW_T - 1);
      S_AR1:   dur_m1 = 8'(ALLRED_T - 1);
      S_EW_G:  dur_m1 = 8'(GREEN_EW - 1);
      S_EW_Y:  dur_m1 = 8'(YELLOW_T - 1);
      S_AR2:   dur_m1 = 8'(ALLRED_T - 1);
      S_WALK:  dur_m1 = 8'(WALK_T - 1);
      default: dur_m1 = 8'd0;
    endcase
  endfunction

  assign expired    = (timer == 8'd0);
  assign entering   = (nxt != state);
  assign enter_ew_g = (nxt == S_EW_G) && (state != S_EW_G);
  assign enter_walk = (nxt == S_WALK) && (state != S_WALK);
  assign state_o    = state;

  // Next-state selection; emergency overrides every other transition.
  always_comb begin
    nxt = state;
    if (emergency) begin
      nxt = S_EMERG;
    end else begin
      case (state)
        S_NS_G:  if (expired && (car_pend || ped_pend)) nxt = S_NS_Y;
        S_NS_Y:  if (expired) nxt = S_AR1;
        S_AR1:   if (expired) nxt = car_pend ? S_EW_G : S_WALK;
        S_EW_G:  if (expired) nxt = S_EW_Y;
        S_EW_Y:  if (expired) nxt = S_AR2;
        S_AR2:   if (expired) nxt = ped_pend ? S_WALK : S_NS_G;
        S_WALK:  if (expired) nxt = S_NS_G;
        S_EMERG: nxt = S_AR2;
        default: nxt = S_NS_G;
      endcase
    end
  end

  // State, dwell timer, pending requests and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_NS_G;
      timer    <= 8'(GREEN_NS - 1);
      car_pend <= 1'b0;
      ped_pend <= 1'b0;
      ns_light <= LIGHT_G;
      ew_light <= LIGHT_R;
      walk     <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      state <= nxt;
      if (entering) begin
        timer <= dur_m1(nxt);
      end else if (!expired) begin
        timer <= timer - 8'd1;
      end
      // Servicing wins over a request sampled on the same edge.
      car_pend <= enter_ew_g ? 1'b0 : (car_pend | ew_car);
      ped_pend <= enter_walk ? 1'b0 : (ped_pend | ped_req);
      ns_light <= (nxt == S_NS_G) ? LIGHT_G : (nxt == S_NS_Y) ? LIGHT_Y : LIGHT_R;
      ew_light <= (nxt == S_EW_G) ? LIGHT_G : (nxt == S_EW_Y) ? LIGHT_Y : LIGHT_R;
      walk     <= (nxt == S_WALK);
      ped_ack  <= enter_walk;
    end
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl against a phase/elapsed-time reference model.
// Directed scenarios for idle, car, pedestrian, combined, emergency and async reset, then random traffic.
// Inputs driven and outputs sampled on the falling edge.
module tb_intersection_ctrl;

  localparam int GREEN_NS = 15;
  localparam int GREEN_EW = 10;
  localparam int YELLOW_T = 3;
  localparam int ALLRED_T = 1;
  localparam int WALK_T   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       ew_car;
  logic       ped_req;
  logic       emergency;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_seen;

  // Reference model: current phase, cycles already spent in it, pending flags, expected ack.
  int m_ph;
  int m_el;
  bit m_cp;
  bit m_pp;
  bit m_ack;

  always #5 clk = ~clk;

  intersection_ctrl #(
    .GREEN_NS(GREEN_NS), .GREEN_EW(GREEN_EW), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .clk(clk), .reset(reset), .ew_car(ew_car), .ped_req(ped_req),
    .emergency(emergency), .ns_light(ns_light), .ew_light(ew_light),
    .walk(walk), .ped_ack(ped_ack), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dwell(input int p);
    case (p)
      0: return GREEN_NS;
      1: return YELLOW_T;
      2: return ALLRED_T;
      3: return GREEN_EW;
      4: return YELLOW_T;
      5: return ALLRED_T;
      6: return WALK_T;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_cp = 0; m_pp = 0; m_ack = 0;
  endtask

  // One clock edge of the reference behaviour, given the inputs sampled on it.
  task automatic model_step(input bit car, input bit ped, input bit em);
    int  np;
    bit  last;
    last = (m_el + 1 >= dwell(m_ph));
    np = m_ph;
    if (em) np = 7;
    else if (m_ph == 7) np = 5;
    else if (last) begin
      case (m_ph)
        0: np = (m_cp || m_pp) ? 1 : 0;
        1: np = 2;
        2: np = m_cp ? 3 : 6;
        3: np = 4;
        4: np = 5;
        5: np = m_pp ? 6 : 0;
        default: np = 0;
      endcase
    end
    m_ack = (np == 6) && (m_ph != 6);
    m_cp  = (np == 3 && m_ph != 3) ? 1'b0 : (m_cp | car);
    m_pp  = (np == 6 && m_ph != 6) ? 1'b0 : (m_pp | ped);
    m_el  = (np != m_ph) ? 0 : m_el + 1;
    m_ph  = np;
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] ns_e, ew_e;
    ns_e = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
    ew_e = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
    check({tag, "_state"}, 32'(state_o), 32'(m_ph));
    check({tag, "_ns"}, 32'(ns_light), 32'(ns_e));
    check({tag, "_ew"}, 32'(ew_light), 32'(ew_e));
    check({tag, "_walk"}, 32'(walk), 32'(m_ph == 6));
    check({tag, "_ack"}, 32'(ped_ack), 32'(m_ack));
    check({tag, "_safe_roads"}, 32'(ns_light != 3'b100 && ew_light != 3'b100), 32'd0);
    check({tag, "_safe_walk"}, 32'(walk && (ns_light != 3'b100 || ew_light != 3'b100)), 32'd0);
    if (ped_ack === 1'b1) ack_seen++;
  endtask

  // Drive inputs at the falling edge, advance one rising edge, check at the next falling edge.
  task automatic cycle(input string tag, input bit car, input bit ped, input bit em);
    ew_car = car; ped_req = ped; emergency = em;
    model_step(car, ped, em);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and confirm the outputs respond with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1; ew_car = 1'b0; ped_req = 1'b0; emergency = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_phase(input string tag, input int ph, input int budget);
    int n = 0;
    while (m_ph != ph && n < budget) begin
      cycle(tag, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check({tag, "_reached_phase"}, 32'(m_ph), 32'(ph));
  endtask

  initial begin
    bit em_lvl;
    reset = 1'b1; ew_car = 1'b0; ped_req = 1'b0; emergency = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;

    // No requests: NS green forever.
    idle("idle", 100);

    // EW car pulse at cycle 2, then no further EW green.
    async_reset("rst_car");
    idle("car", 2);
    cycle("car", 1'b1, 1'b0, 1'b0);
    idle("car", 80);

    // Pedestrian only.
    async_reset("rst_ped");
    ack_seen = 0;
    idle("ped", 3);
    cycle("ped", 1'b0, 1'b1, 1'b0);
    idle("ped", 50);
    check("ped_ack_count", 32'(ack_seen), 32'd1);

    // Car and pedestrian both during NS green.
    async_reset("rst_both");
    ack_seen = 0;
    idle("both", 3);
    cycle("both", 1'b1, 1'b0, 1'b0);
    idle("both", 2);
    cycle("both", 1'b0, 1'b1, 1'b0);
    idle("both", 60);
    check("both_ack_count", 32'(ack_seen), 32'd1);

    // Emergency for 5 cycles in the middle of EW green, pedestrian still pending.
    async_reset("rst_emerg");
    cycle("emerg", 1'b1, 1'b1, 1'b0);
    run_until_phase("emerg", 3, 40);
    idle("emerg", 3);
    for (int i = 0; i < 5; i++) cycle("emerg_on", 1'b0, 1'b0, 1'b1);
    idle("emerg_off", 40);

    // Reset during WALK, then a pedestrian request in the release cycle.
    async_reset("rst_walk0");
    cycle("walk", 1'b0, 1'b1, 1'b0);
    run_until_phase("walk", 6, 40);
    idle("walk", 3);
    async_reset("rst_walk");
    cycle("rel", 1'b0, 1'b1, 1'b0);
    idle("rel", 40);

    // Random traffic, emergencies and occasional resets.
    em_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
      if (em_lvl) em_lvl = ($urandom_range(0, 5) != 0);
      else        em_lvl = ($urandom_range(0, 149) == 0);
      cycle("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0), em_lvl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
